// File: rtl/uart_frame_loader.sv
// Sync-byte framed loader: gathers N sign-extended payload bytes and hands them to the Hopfield core.
// Define UART_FRAME_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module uart_frame_loader #(
    parameter int unsigned N            = 9,
    parameter int unsigned SIZE         = 32,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic              core_done,
    output logic [N*SIZE-1:0] data,
    output logic              start,
    output logic              busy,
    output logic [1:0]        err
);
    localparam int unsigned   CW       = $clog2(N + 1);
    localparam int unsigned   TW       = (TIMEOUT_CLKS == 0) ? 1 : $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_OVR = 2'b11;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM = 2'b01;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
        CHECK,
`endif
        COMMIT,
        WAIT_CORE
    } state_t;

    state_t            state_reg, state_next;
    logic [N*SIZE-1:0] shadow_reg, shadow_next;
    logic [N*SIZE-1:0] data_reg, data_next;
    logic [N*SIZE-1:0] shadow_shifted;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic [1:0]        err_reg, err_next;
    logic              start_reg, start_next;
    logic [SIZE-1:0]   byte_ext;
    logic              tmo_hit;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]        xor_reg, xor_next;
`endif

    assign byte_ext = SIZE'($signed(rx_byte));

    // Shift by whole words: word gi takes word gi-1, the new byte lands in word 0.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            if (gi == 0) begin : g_low
                assign shadow_shifted[SIZE-1:0] = byte_ext;
            end else begin : g_up
                assign shadow_shifted[gi*SIZE +: SIZE] = shadow_reg[(gi-1)*SIZE +: SIZE];
            end
        end
    endgenerate

    // Fires on the TIMEOUT_CLKS-th consecutive idle cycle inside a frame.
    assign tmo_hit = (TIMEOUT_CLKS != 0) && (tmo_reg == TMO_LAST) && !rx_dv;

    always_comb begin
        state_next  = state_reg;
        shadow_next = shadow_reg;
        data_next   = data_reg;
        cnt_next    = cnt_reg;
        tmo_next    = tmo_reg;
        err_next    = err_reg;
        start_next  = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        xor_next    = xor_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) begin
                    state_next  = PAYLOAD;
                    shadow_next = '0;
                    cnt_next    = '0;
                    tmo_next    = '0;
                    err_next    = ERR_OK;
`ifdef UART_FRAME_CHECKSUM_EN
                    xor_next    = 8'h00;
`endif
                end
            end
            PAYLOAD: begin
                if (rx_dv) begin
                    shadow_next = shadow_shifted;
                    cnt_next    = cnt_reg + CW'(1);
                    tmo_next    = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                    xor_next    = xor_reg ^ rx_byte;
                    if (cnt_reg == CNT_LAST) state_next = CHECK;
`else
                    if (cnt_reg == CNT_LAST) state_next = COMMIT;
`endif
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    err_next   = ERR_TMO;
                end else if (TIMEOUT_CLKS != 0) begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CHECK: begin
                if (rx_dv) begin
                    tmo_next = '0;
                    if (rx_byte == xor_reg) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = IDLE;
                        err_next   = ERR_CSUM;
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    err_next   = ERR_TMO;
                end else if (TIMEOUT_CLKS != 0) begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
`endif
            COMMIT: begin
                data_next  = shadow_reg;
                start_next = 1'b1;
                state_next = WAIT_CORE;
                if (rx_dv) err_next = ERR_OVR;
            end
            WAIT_CORE: begin
                // A byte arriving together with core_done is dropped silently.
                if (core_done)  state_next = IDLE;
                else if (rx_dv) err_next   = ERR_OVR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            shadow_reg <= '0;
            data_reg   <= '0;
            cnt_reg    <= '0;
            tmo_reg    <= '0;
            err_reg    <= ERR_OK;
            start_reg  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            xor_reg    <= 8'h00;
`endif
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;
            data_reg   <= data_next;
            cnt_reg    <= cnt_next;
            tmo_reg    <= tmo_next;
            err_reg    <= err_next;
            start_reg  <= start_next;
`ifdef UART_FRAME_CHECKSUM_EN
            xor_reg    <= xor_next;
`endif
        end
    end

    assign data  = data_reg;
    assign start = start_reg;
    assign busy  = (state_reg != IDLE);
    assign err   = err_reg;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized self-checking bench for uart_frame_loader (N=9, SIZE=32, TIMEOUT_CLKS=100).
module tb_uart_frame_loader;
    localparam int         N    = 9;
    localparam int         SIZE = 32;
    localparam int         TMO  = 100;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] payload_t [N];

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              core_done;
    logic [N*SIZE-1:0] data;
    logic              start;
    logic              busy;
    logic [1:0]        err;

    int compared   = 0;
    int mismatched = 0;
    int start_cnt  = 0;
    int exp_starts = 0;
    logic [N*SIZE-1:0] exp_data;
    logic [N*SIZE-1:0] vec;
    payload_t          p;

    uart_frame_loader #(.N(N), .SIZE(SIZE), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .core_done(core_done),
        .data(data), .start(start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Value read at a posedge is what start showed during the previous cycle.
    always @(posedge clk) if (start === 1'b1) start_cnt++;

    // Reference: byte i becomes word (N-1-i), sign-extended to SIZE bits.
    function automatic logic [N*SIZE-1:0] model_vec(input payload_t b);
        logic [N*SIZE-1:0] v;
        logic signed [SIZE-1:0] w;
        v = '0;
        for (int i = 0; i < N; i++) begin
            w = SIZE'($signed(b[i]));
            v[(N-1-i)*SIZE +: SIZE] = w;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_xor(input payload_t b);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < N; i++) x = x ^ b[i];
        return x;
    endfunction

    function automatic payload_t rand_payload();
        payload_t r;
        for (int i = 0; i < N; i++) r[i] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    // One clock cycle of stimulus, applied at a negedge and released at the next.
    task automatic cyc(input logic dv, input logic [7:0] b, input logic done);
        rx_dv = dv; rx_byte = b; core_done = done;
        @(negedge clk);
        rx_dv = 1'b0; core_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input payload_t b, input logic [7:0] csum_flip, input int max_gap);
        cyc(1'b1, SYNC, 1'b0);
        for (int i = 0; i < N; i++) begin
            idle($urandom_range(0, max_gap));
            cyc(1'b1, b[i], 1'b0);
        end
        if (CSUM_EN) begin
            idle($urandom_range(0, max_gap));
            cyc(1'b1, model_xor(b) ^ csum_flip, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; core_done = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (data !== '0)    begin mismatched++; $display("FAIL reset_data: got %h want 0", data); end
        compared++; if (start !== 1'b0) begin mismatched++; $display("FAIL reset_start: got %b want 0", start); end
        compared++; if (busy !== 1'b0)  begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (err !== 2'b00)  begin mismatched++; $display("FAIL reset_err: got %b want 00", err); end
        rst = 1'b0;
        @(negedge clk);
        exp_data = '0;
        $display("reset: outputs checked");
    endtask

    task automatic test_valid_frame();
        for (int i = 0; i < N; i++) p[i] = 8'(i + 1);
        vec = model_vec(p);
        send_frame(p, 8'h00, 0);
        compared++; if (start !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL valid_commit_cycle: got start=%b busy=%b want start=0 busy=1", start, busy); end
        idle(1);
        exp_starts++;
        compared++; if (start !== 1'b1) begin mismatched++; $display("FAIL valid_start: got %b want 1", start); end
        compared++; if (data[N*SIZE-1 -: SIZE] !== 32'h00000001) begin mismatched++; $display("FAIL valid_top_word: got %h want 00000001", data[N*SIZE-1 -: SIZE]); end
        compared++; if (data[SIZE-1:0] !== 32'h00000009) begin mismatched++; $display("FAIL valid_low_word: got %h want 00000009", data[SIZE-1:0]); end
        idle(1);
        compared++; if (start !== 1'b0) begin mismatched++; $display("FAIL valid_start_width: got %b want 0", start); end
        idle(5);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL valid_busy_hold: got %b want 1", busy); end
        cyc(1'b0, 8'h00, 1'b1);
        compared++; if (busy !== 1'b0 || err !== 2'b00) begin mismatched++; $display("FAIL valid_done: got busy=%b err=%b want busy=0 err=00", busy, err); end
        exp_data = vec;
        $display("valid_frame: data=%h", data);
    endtask

    task automatic test_sign_ext();
        for (int i = 0; i < N; i++) p[i] = 8'h00;
        p[0] = 8'h80; p[1] = 8'h7F;
        send_frame(p, 8'h00, 1);
        idle(1);
        exp_starts++;
        compared++; if (data[N*SIZE-1 -: SIZE] !== 32'hFFFFFF80) begin mismatched++; $display("FAIL sign_top_word: got %h want FFFFFF80", data[N*SIZE-1 -: SIZE]); end
        compared++; if (data[N*SIZE-SIZE-1 -: SIZE] !== 32'h0000007F) begin mismatched++; $display("FAIL sign_second_word: got %h want 0000007F", data[N*SIZE-SIZE-1 -: SIZE]); end
        cyc(1'b0, 8'h00, 1'b1);
        exp_data = model_vec(p);
        $display("sign_ext: top=%h next=%h", data[N*SIZE-1 -: SIZE], data[N*SIZE-SIZE-1 -: SIZE]);
    endtask

    task automatic test_random_frames();
        logic [7:0] g;
        for (int t = 0; t < 8; t++) begin
            p = rand_payload();
            if (t % 2 == 0) p[$urandom_range(0, N-1)] = SYNC;
            // Junk before the sync byte must be discarded.
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == SYNC) g = g ^ 8'h01;
                cyc(1'b1, g, 1'b0);
            end
            vec = model_vec(p);
            send_frame(p, 8'h00, (t % 2 == 0) ? 0 : 3);
            idle(1);
            exp_starts++;
            compared++; if (start !== 1'b1 || data !== vec) begin mismatched++; $display("FAIL random_frame%0d: got start=%b data=%h want start=1 data=%h", t, start, data, vec); end
            idle($urandom_range(0, 4));
            cyc(1'b0, 8'h00, 1'b1);
            compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL random_release%0d: got busy=%b want 0", t, busy); end
            exp_data = vec;
            $display("random_frame %0d: data=%h", t, data);
        end
    endtask

    task automatic test_bad_checksum();
`ifdef UART_FRAME_CHECKSUM_EN
        p = rand_payload();
        send_frame(p, 8'h01, 0);
        compared++; if (busy !== 1'b0 || err !== 2'b01) begin mismatched++; $display("FAIL csum_err: got busy=%b err=%b want busy=0 err=01", busy, err); end
        idle(2);
        compared++; if (start !== 1'b0 || data !== exp_data) begin mismatched++; $display("FAIL csum_data_kept: got start=%b data=%h want start=0 data=%h", start, data, exp_data); end
        $display("bad_checksum: err=%b", err);
`else
        $display("bad_checksum: checksum not built in");
`endif
    endtask

    task automatic test_timeout();
        p = rand_payload();
        cyc(1'b1, SYNC, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, p[i], 1'b0);
        idle(TMO - 1);
        compared++; if (busy !== 1'b1 || err !== 2'b00) begin mismatched++; $display("FAIL timeout_early: got busy=%b err=%b want busy=1 err=00", busy, err); end
        idle(1);
        compared++; if (busy !== 1'b0 || err !== 2'b10) begin mismatched++; $display("FAIL timeout_fire: got busy=%b err=%b want busy=0 err=10", busy, err); end
        compared++; if (data !== exp_data) begin mismatched++; $display("FAIL timeout_data_kept: got %h want %h", data, exp_data); end
        p = rand_payload();
        vec = model_vec(p);
        send_frame(p, 8'h00, 2);
        idle(1);
        exp_starts++;
        compared++; if (start !== 1'b1 || data !== vec || err !== 2'b00) begin mismatched++; $display("FAIL timeout_recover: got start=%b err=%b data=%h want start=1 err=00 data=%h", start, err, data, vec); end
        cyc(1'b0, 8'h00, 1'b1);
        exp_data = vec;
        $display("timeout: recovered data=%h", data);
    endtask

    task automatic test_overrun();
        p = rand_payload();
        vec = model_vec(p);
        send_frame(p, 8'h00, 0);
        idle(1);
        exp_starts++;
        cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        compared++; if (err !== 2'b11 || busy !== 1'b1 || data !== vec) begin mismatched++; $display("FAIL overrun_flag: got err=%b busy=%b want err=11 busy=1", err, busy); end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h3C, 1'b0);
        compared++; if (err !== 2'b11 || busy !== 1'b0) begin mismatched++; $display("FAIL overrun_sticky: got err=%b busy=%b want err=11 busy=0", err, busy); end
        exp_data = vec;
        $display("overrun: err=%b", err);
    endtask

    task automatic test_simultaneous();
        p = rand_payload();
        vec = model_vec(p);
        send_frame(p, 8'h00, 0);
        compared++; if (err !== 2'b00) begin mismatched++; $display("FAIL simul_err_cleared: got %b want 00", err); end
        idle(1);
        exp_starts++;
        cyc(1'b1, SYNC, 1'b1);
        compared++; if (busy !== 1'b0 || err !== 2'b00) begin mismatched++; $display("FAIL simul_drop: got busy=%b err=%b want busy=0 err=00", busy, err); end
        idle(2);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL simul_no_frame: got busy=%b want 0", busy); end
        exp_data = vec;
        $display("simultaneous: busy=%b err=%b", busy, err);
    endtask

    task automatic test_core_done_ignored();
        cyc(1'b0, 8'h00, 1'b1);
        compared++; if (busy !== 1'b0 || start !== 1'b0) begin mismatched++; $display("FAIL done_in_idle: got busy=%b start=%b want 0 0", busy, start); end
        p = rand_payload();
        vec = model_vec(p);
        cyc(1'b1, SYNC, 1'b0);
        for (int i = 0; i < N; i++) cyc(1'b1, p[i], (i == 4) ? 1'b1 : 1'b0);
        if (CSUM_EN) cyc(1'b1, model_xor(p), 1'b1);
        idle(1);
        exp_starts++;
        compared++; if (start !== 1'b1 || data !== vec) begin mismatched++; $display("FAIL done_in_payload: got start=%b data=%h want start=1 data=%h", start, data, vec); end
        cyc(1'b0, 8'h00, 1'b1);
        exp_data = vec;
        $display("core_done_ignored: data=%h", data);
    endtask

    task automatic test_reset_midframe();
        p = rand_payload();
        cyc(1'b1, SYNC, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, p[i], 1'b0);
        #2 rst = 1'b1;
        #1;
        compared++; if (data !== '0 || start !== 1'b0 || busy !== 1'b0 || err !== 2'b00) begin mismatched++; $display("FAIL async_reset: got data=%h start=%b busy=%b err=%b want all zero", data, start, busy, err); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p = rand_payload();
        vec = model_vec(p);
        send_frame(p, 8'h00, 1);
        idle(1);
        exp_starts++;
        compared++; if (start !== 1'b1 || data !== vec) begin mismatched++; $display("FAIL reset_reload: got start=%b data=%h want start=1 data=%h", start, data, vec); end
        cyc(1'b0, 8'h00, 1'b1);
        exp_data = vec;
        $display("reset_midframe: reload data=%h", data);
    endtask

    task automatic test_pulse_count();
        idle(3);
        compared++; if (start_cnt !== exp_starts) begin mismatched++; $display("FAIL start_pulse_count: got %0d want %0d", start_cnt, exp_starts); end
        $display("pulse_count: %0d start pulses", start_cnt);
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_sign_ext();
        test_random_frames();
        test_bad_checksum();
        test_timeout();
        test_overrun();
        test_simultaneous();
        test_core_done_ignored();
        test_reset_midframe();
        test_pulse_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
